// File: rtl/period_meter.sv
// Reference period meter: synchronises sig_in, counts clk cycles between rising
// edges, and reports period length, a stability flag and loss-of-reference timeout.
module period_meter #(
    parameter int WIDTH        = 16,
    parameter int STABLE_COUNT = 4,
    parameter int TOL          = 0,
    parameter int TIMEOUT      = 65535
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             PWRDWN,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_length,
    output logic             period_valid,
    output logic             period_stable,
    output logic             timeout
);

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);
    localparam logic [WIDTH:0]   TOL_V     = (WIDTH+1)'(TOL);
    localparam logic [7:0]       STABLE_V  = 8'(STABLE_COUNT);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic             at_timeout;
    logic             match;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] count, count_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic             prev_valid, prev_valid_nxt;
    logic [7:0]       stable_cnt, stable_cnt_nxt;
    logic [WIDTH-1:0] length_nxt;
    logic             valid_nxt, stable_nxt, timeout_nxt;

    assign rise       = s2 & ~s3;
    assign at_timeout = (count == TIMEOUT_V);

    // Unsigned magnitude of the difference against the previous measurement.
    always_comb begin
        if (count >= prev) begin
            diff = {1'b0, count} - {1'b0, prev};
        end else begin
            diff = {1'b0, prev} - {1'b0, count};
        end
        match = (diff <= TOL_V);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (RST || PWRDWN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an edge coinciding with the timeout count wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (at_timeout) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        count_nxt      = count;
        length_nxt     = period_length;
        valid_nxt      = 1'b0;
        prev_nxt       = prev;
        prev_valid_nxt = prev_valid;
        stable_cnt_nxt = stable_cnt;
        timeout_nxt    = timeout;
        case (state)
            IDLE: begin
                if (rise) begin
                    count_nxt   = {{(WIDTH-1){1'b0}}, 1'b1};
                    timeout_nxt = 1'b0;
                end else begin
                    count_nxt = {WIDTH{1'b0}};
                end
            end
            MEASURE: begin
                if (rise) begin
                    count_nxt      = {{(WIDTH-1){1'b0}}, 1'b1};
                    length_nxt     = count;
                    valid_nxt      = 1'b1;
                    prev_nxt       = count;
                    prev_valid_nxt = 1'b1;
                    if (!prev_valid) begin
                        stable_cnt_nxt = 8'd0;
                    end else if (match) begin
                        stable_cnt_nxt = (stable_cnt >= STABLE_V) ? STABLE_V : stable_cnt + 8'd1;
                    end else begin
                        stable_cnt_nxt = 8'd0;
                    end
                end else if (at_timeout) begin
                    count_nxt      = {WIDTH{1'b0}};
                    timeout_nxt    = 1'b1;
                    stable_cnt_nxt = 8'd0;
                    prev_valid_nxt = 1'b0;
                end else begin
                    count_nxt = (count == CNT_MAX) ? count : count + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: count_nxt = {WIDTH{1'b0}};
        endcase
        stable_nxt = (stable_cnt_nxt == STABLE_V);
    end

    // Synchroniser, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (RST || PWRDWN) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            count         <= {WIDTH{1'b0}};
            prev          <= {WIDTH{1'b0}};
            prev_valid    <= 1'b0;
            stable_cnt    <= 8'd0;
            period_length <= {WIDTH{1'b0}};
            period_valid  <= 1'b0;
            period_stable <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            s1            <= sig_in;
            s2            <= s1;
            s3            <= s2;
            count         <= count_nxt;
            prev          <= prev_nxt;
            prev_valid    <= prev_valid_nxt;
            stable_cnt    <= stable_cnt_nxt;
            period_length <= length_nxt;
            period_valid  <= valid_nxt;
            period_stable <= stable_nxt;
            timeout       <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: drives sig_in waveforms, predicts each
// measurement in a scoreboard queue and compares it when period_valid fires.
module tb_period_meter;

    localparam int WIDTH = 16;
    localparam int SC    = 4;
    localparam int TOLP  = 1;
    localparam int TMO   = 100;

    typedef struct {
        int len;
        bit stab;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwrdwn = 1'b0;
    logic             sig_in = 1'b0;
    logic [WIDTH-1:0] period_length;
    logic             period_valid;
    logic             period_stable;
    logic             timeout;

    int   passed = 0;
    int   total = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q[$];

    bit   m_active = 1'b0;
    bit   m_prev_valid = 1'b0;
    int   m_prev = 0;
    int   m_st = 0;
    int   m_last = 0;

    period_meter #(.WIDTH(WIDTH), .STABLE_COUNT(SC), .TOL(TOLP), .TIMEOUT(TMO)) dut (
        .clk(clk), .RST(rst), .PWRDWN(pwrdwn), .sig_in(sig_in),
        .period_length(period_length), .period_valid(period_valid),
        .period_stable(period_stable), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_active     = 1'b0;
        m_prev_valid = 1'b0;
        m_st         = 0;
    endtask

    // Drive a rising edge and predict the measurement it closes.
    task automatic rise();
        int m, d;
        exp_t e;
        sig_in = 1'b1;
        if (m_active) begin
            m = cyc - m_last;
            d = (m > m_prev) ? m - m_prev : m_prev - m;
            if (!m_prev_valid) m_st = 0;
            else if (d <= TOLP) m_st = (m_st + 1 > SC) ? SC : m_st + 1;
            else m_st = 0;
            m_prev = m;
            m_prev_valid = 1'b1;
            e.len = m;
            e.stab = (m_st == SC);
            q.push_back(e);
        end
        m_active = 1'b1;
        m_last = cyc;
    endtask

    task automatic wave(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            rise();
            repeat (p / 2) @(negedge clk);
            sig_in = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_len"}, 32'(period_length), 32'd0);
        check({tag, "_valid"}, 32'(period_valid), 32'd0);
        check({tag, "_stable"}, 32'(period_stable), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    // Scoreboard: every valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !pwrdwn && period_valid) begin
            check("spurious_valid", 32'(period_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                e = q.pop_front();
                check("length", 32'(period_length), 32'(e.len));
                check("stable", 32'(period_stable), 32'(e.stab));
                check("timeout_on_valid", 32'(timeout), 32'd0);
            end
        end
    end

    initial begin
        int n;
        // Reset with sig_in toggling.
        repeat (3) begin
            @(negedge clk);
            sig_in = ~sig_in;
            check_zero("rst");
        end
        rst = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        check_zero("post_rst");
        repeat (3) @(negedge clk);

        // Steady 20, switch to 10, then TOL alternation and a jump.
        wave(20, 7);
        wave(10, 6);
        for (int i = 0; i < 4; i++) begin
            wave(20, 1);
            wave(21, 1);
        end
        wave(23, 1);
        wave(20, 6);

        // Last edge, then stop and expect timeout exactly TMO cycles later.
        rise();
        n = 0;
        while (!period_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("last_valid_seen", 32'(period_valid), 32'd1);
        check("pre_timeout_stable", 32'(period_stable), 32'd1);
        sig_in = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        check("timeout_early", 32'(timeout), 32'd0);
        @(negedge clk);
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_stable", 32'(period_stable), 32'd0);
        check("timeout_len_kept", 32'(period_length), 32'd20);
        model_clear();
        repeat (20) @(negedge clk);
        check("timeout_held", 32'(timeout), 32'd1);

        // Restart: timeout clears as the first edge is seen.
        rise();
        repeat (2) @(negedge clk);
        check("timeout_before_edge", 32'(timeout), 32'd1);
        @(negedge clk);
        check("timeout_cleared", 32'(timeout), 32'd0);
        repeat (10 - 3) @(negedge clk);
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        wave(20, 3);

        // Power-down mid-measurement.
        repeat (2) @(negedge clk);
        pwrdwn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_zero("pwrdwn");
        end
        pwrdwn = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        wave(20, 3);

        // Edge arriving exactly at the timeout count wins.
        wave(TMO, 3);
        check("edge_at_timeout_no_loss", 32'(timeout), 32'd0);
        rise();
        repeat (10) @(negedge clk);
        sig_in = 1'b0;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of an incoming reference signal in `clk` cycles.
- Reports the last measured length, a per-measurement valid strobe, and a `period_stable` flag.
- Front end that feeds `freq_gen`: `freq_gen` consumes `ref_period` and `period_stable`; this block derives both from a live signal.
- Also flags loss of the reference through a timeout.

Parameters:
- WIDTH, 16, width of the period counter and of `period_length`.
- STABLE_COUNT, 4, consecutive matching measurements required before `period_stable` asserts (1..255).
- TOL, 0, maximum absolute difference in cycles between successive measurements still counted as matching.
- TIMEOUT, 65535, cycles without a rising edge before a loss is declared (must be ≤ 2**WIDTH-1).

Ports:
- clk  in  1  sampling clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- PWRDWN  in  1  active-high power-down; same effect as RST while high.
- sig_in  in  1  measured signal, asynchronous to `clk`.
- period_length  out  WIDTH  last completed period in `clk` cycles.
- period_valid  out  1  one-cycle pulse when `period_length` updates.
- period_stable  out  1  high while successive measurements match.
- timeout  out  1  high while the reference is considered lost.

Behaviour:
- **Reset / power-down.** RST or PWRDWN sampled high sets:
  - all outputs to 0;
  - synchroniser stages to 0, counter to 0, `stable_cnt` to 0;
  - state to IDLE.
  - RST mid-measurement discards the partial count; there is no pulse on exit.
- **Input path.**
  - `sig_in` passes through 2 flops (s1, s2), then a history flop s3.
  - `edge` = s2 & ~s3, i.e. a rising edge seen 2 clk after capture into s1.
- **State IDLE.**
  - Counter held at 0; `period_valid` stays 0.
  - On `edge`: load counter with 1, go to MEASURE. The first edge never produces a measurement.
- **State MEASURE, no edge this cycle.** Counter increments, saturating at 2**WIDTH-1.
- **State MEASURE, on `edge`.** In the next cycle:
  - `period_length` = counter value;
  - `period_valid` = 1 for exactly 1 cycle.
  - Counter reloads to 1 in the same cycle as `edge`.
  - Result: for a `sig_in` period of P `clk` cycles, `period_length` = P.
- **Stability, evaluated on each measurement m.** Let prev be the previous measurement, if one exists.
  - No prev (first after IDLE): `stable_cnt` = 0.
  - |m - prev| ≤ TOL: `stable_cnt` = min(`stable_cnt`+1, STABLE_COUNT).
  - Otherwise: `stable_cnt` = 0.
  - `period_stable` = (`stable_cnt` == STABLE_COUNT). It updates in the same cycle as `period_valid`.
  - On a mismatch, `period_stable` falls in that cycle.
- **Timeout.**
  - In MEASURE, when counter reaches TIMEOUT without `edge`:
    - `timeout` = 1, `period_stable` = 0, `stable_cnt` = 0, prev invalidated, state to IDLE.
    - `period_length` keeps its last value.
  - `timeout` clears on the next `edge`, in the same cycle IDLE→MEASURE occurs.
- **Simultaneous events.**
  - `edge` in the cycle the counter hits TIMEOUT: the edge wins; a normal measurement of TIMEOUT is produced and no timeout is raised.
  - RST/PWRDWN override everything.
- **Arithmetic.**
  - Difference is computed in WIDTH+1 bits, unsigned magnitude.
  - The comparison with TOL is unsigned.
  - A saturated counter yields `period_length` = 2**WIDTH-1.

Test Plan:
1. RST high 3 cycles with `sig_in` toggling → all outputs 0 during and one cycle after; no `period_valid` until 2 `sig_in` rising edges have occurred.
2. `sig_in` square wave with period 20 clk, STABLE_COUNT=4, TOL=0 → each `period_valid` shows `period_length`=20; `period_stable` rises with the 5th pulse (6th edge) and stays high.
3. After stable at 20, switch to period 10 → first mismatching pulse drops `period_stable`; later pulses show 10; `period_stable` reasserts on the 4th consecutive matching 10.
4. TOL=1, periods alternating 20/21 → `period_stable` reaches 1 after 5 pulses; a jump to 23 clears it on that pulse.
5. TIMEOUT=100, stop `sig_in` after stable at 20 → `timeout`=1 and `period_stable`=0 exactly 100 cycles after the last edge reload; `period_length` stays 20; restart → `timeout` clears on the first edge, and the first `period_valid` comes on the second edge.
6. PWRDWN pulsed for 5 cycles mid-measurement → outputs 0 during the pulse; the counter restarts from IDLE afterwards; no partial-period value is ever reported.
